// File: rtl/fpu_pkg.sv
// fpu_pkg: fpusel opcodes, dispatcher FSM states, canonical NaN
// and the opcode -> execution-unit mapping shared by fpu_dispatch.
package fpu_pkg;

  localparam logic [4:0] OP_FADD    = 5'b00000;
  localparam logic [4:0] OP_FSUB    = 5'b00001;
  localparam logic [4:0] OP_FMUL    = 5'b00010;
  localparam logic [4:0] OP_FDIV    = 5'b00011;
  localparam logic [4:0] OP_RSVD    = 5'b00100;
  localparam logic [4:0] OP_COMB_LO = 5'b00101;
  localparam logic [4:0] OP_COMB_HI = 5'b01111;
  localparam logic [2:0] OP_FMA_PFX = 3'b100;
  localparam logic [2:0] OP_CVT_PFX = 3'b101;

  localparam logic [31:0] CANON_NAN = 32'h7fc00000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    K_MULTI,
    K_COMB,
    K_BAD
  } kind_e;

  function automatic kind_e op_kind(
    input logic [4:0] op
  );
    kind_e k;
    k = K_BAD;
    unique case (1'b1)
      op inside {[OP_COMB_LO:OP_COMB_HI]}:
        k = K_COMB;
      op <= OP_FDIV:
        k = K_MULTI;
      op[4:3] == 2'b10:
        k = K_MULTI;
      default:
        k = K_BAD;
    endcase
    return k;
  endfunction

  // -1 means the opcode has no execution unit
  function automatic int op_unit(
    input logic [4:0] op,
    input int         n_units
  );
    int u;
    u = -1;
    unique case (1'b1)
      op == OP_FADD,
      op == OP_FSUB:
        u = 0;
      op == OP_FMUL:
        u = 1;
      op == OP_FDIV:
        u = 2;
      op[4:2] == OP_FMA_PFX:
        u = 3;
      op[4:2] == OP_CVT_PFX:
        u = (n_units > 4) ? 4 : 3;
      default:
        u = -1;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/fpu_dispatch.sv
// fpu_dispatch: sequences one FP op at a time onto multi-cycle
// units or the combinational datapath and returns the result.
//
// Ports: g_clk/g_rst_n (async active-low); req_* request in
// (valid/ready); unit_start/unit_a/b/c/rm to units; unit_done/
// unit_res back; comb_res from the comb ops on unit_a/unit_b;
// rsp_* response out (valid/ready); stall pipeline hold.
// Macro FPU_DISPATCH_TIMEOUT_EN adds a WAIT-state watchdog.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int N_UNITS     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    g_clk,
  input  logic                    g_rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [4:0]              req_op,
  input  logic [XLEN-1:0]         req_a,
  input  logic [XLEN-1:0]         req_b,
  input  logic [XLEN-1:0]         req_c,
  input  logic [2:0]              req_rm,
  output logic [N_UNITS-1:0]      unit_start,
  output logic [XLEN-1:0]         unit_a,
  output logic [XLEN-1:0]         unit_b,
  output logic [XLEN-1:0]         unit_c,
  output logic [2:0]              unit_rm,
  input  logic [N_UNITS-1:0]      unit_done,
  input  logic [N_UNITS*XLEN-1:0] unit_res,
  input  logic [XLEN-1:0]         comb_res,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [XLEN-1:0]         rsp_res,
  output logic                    rsp_err,
  output logic                    stall
);

  localparam int IW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam logic [XLEN-1:0] NAN_X = XLEN'(CANON_NAN);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] ua_q, ua_d;
  logic [XLEN-1:0] ub_q, ub_d;
  logic [XLEN-1:0] uc_q, uc_d;
  logic [2:0]      rm_q, rm_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            err_q, err_d;
  // first RESP cycle of a comb op: comb_res is live, not yet captured
  logic            comb_q, comb_d;

`ifdef FPU_DISPATCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  kind_e           req_kind;
  int              req_unit;
  logic            req_bad;
  logic            sel_done;
  logic [XLEN-1:0] sel_res;

  assign req_kind = op_kind(req_op);
  assign req_unit = op_unit(req_op, N_UNITS);
  assign req_bad  = (req_kind == K_BAD) ||
                    (req_kind == K_MULTI &&
                     req_unit >= N_UNITS);

  always_comb begin
    sel_done = 1'b0;
    sel_res  = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (IW'(i) == idx_q) begin
        sel_done = unit_done[i];
        sel_res  = unit_res[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ua_d    = ua_q;
    ub_d    = ub_q;
    uc_d    = uc_q;
    rm_d    = rm_q;
    res_d   = res_q;
    err_d   = err_q;
    comb_d  = comb_q;
`ifdef FPU_DISPATCH_TIMEOUT_EN
    cnt_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          ua_d  = req_a;
          ub_d  = (req_op == OP_FSUB) ?
                  {~req_b[XLEN-1], req_b[XLEN-2:0]} :
                  req_b;
          uc_d  = req_c;
          rm_d  = req_rm;
          err_d = 1'b0;
          if (req_bad) begin
            res_d   = NAN_X;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_kind == K_COMB) begin
            comb_d  = 1'b1;
            state_d = RESP;
          end else begin
            idx_d   = IW'(req_unit);
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (sel_done) begin
          res_d   = sel_res;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sel_done) begin
          res_d   = sel_res;
          state_d = RESP;
        end else begin
`ifdef FPU_DISPATCH_TIMEOUT_EN
          if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            res_d   = NAN_X;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      RESP: begin
        if (comb_q) begin
          res_d  = comb_res;
          comb_d = 1'b0;
        end
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ua_q    <= '0;
      ub_q    <= '0;
      uc_q    <= '0;
      rm_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      comb_q  <= 1'b0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
      uc_q    <= uc_d;
      rm_q    <= rm_d;
      res_q   <= res_d;
      err_q   <= err_d;
      comb_q  <= comb_d;
`ifdef FPU_DISPATCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign stall      = (state_q != IDLE) ||
                      (req_valid && !req_ready);
  assign unit_start = (state_q == ISSUE) ?
                      (N_UNITS'(1) << idx_q) : '0;
  assign unit_a     = ua_q;
  assign unit_b     = ub_q;
  assign unit_c     = uc_q;
  assign unit_rm    = rm_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_res    = comb_q ? comb_res : res_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// tb_fpu_dispatch: directed + random transactions against a
// transaction-level reference model of fpu_dispatch.
module tb_fpu_dispatch;

  localparam int XLEN = 32;
  localparam int NU   = 4;
  localparam logic [31:0] QNAN = 32'h7fc00000;

  logic            g_clk = 1'b0;
  logic            g_rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [4:0]      req_op = '0;
  logic [31:0]     req_a = '0;
  logic [31:0]     req_b = '0;
  logic [31:0]     req_c = '0;
  logic [2:0]      req_rm = '0;
  logic [NU-1:0]   unit_start;
  logic [31:0]     unit_a, unit_b, unit_c;
  logic [2:0]      unit_rm;
  logic [NU-1:0]   unit_done = '0;
  logic [NU*32-1:0] unit_res = '0;
  logic [31:0]     comb_res;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [31:0]     rsp_res;
  logic            rsp_err;
  logic            stall;

  logic            comb_fix_en = 1'b0;
  logic [31:0]     comb_fix = '0;

  int n_chk = 0;
  int n_fail = 0;

  // stand-in comb unit working on the latched operands
  assign comb_res = comb_fix_en ? comb_fix : (unit_a ^ unit_b);

  always #5 g_clk = ~g_clk;

  fpu_dispatch #(
    .XLEN(XLEN), .N_UNITS(NU), .TIMEOUT_CYC(64)
  ) dut (
    .g_clk(g_clk), .g_rst_n(g_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_c(req_c), .req_rm(req_rm),
    .unit_start(unit_start), .unit_a(unit_a),
    .unit_b(unit_b), .unit_c(unit_c), .unit_rm(unit_rm),
    .unit_done(unit_done), .unit_res(unit_res),
    .comb_res(comb_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_err(rsp_err), .stall(stall)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // 0 = multi-cycle unit, 1 = combinational, 2 = unmapped
  function automatic int exp_kind(input logic [4:0] op);
    if (op == 5'd4 || op >= 5'd24) return 2;
    if (op >= 5'd5 && op <= 5'd15) return 1;
    return 0;
  endfunction

  function automatic int exp_unit(input logic [4:0] op);
    if (op <= 5'd1) return 0;
    if (op == 5'd2) return 1;
    if (op == 5'd3) return 2;
    return 3;
  endfunction

  task automatic run_txn(input logic [4:0] op,
                         input logic [31:0] a, b, c,
                         input logic [2:0] rm,
                         input int dly, input int hold,
                         input bit noise,
                         input logic [31:0] ures,
                         input bit bypass);
    int k, u;
    logic [31:0] beff, eres;
    logic eerr;
    k = exp_kind(op);
    u = exp_unit(op);
    beff = (op == 5'd1) ? {~b[31], b[30:0]} : b;
    @(negedge g_clk);
    chk("idle_ready", req_ready, 1);
    req_valid = 1; req_op = op;
    req_a = a; req_b = b; req_c = c; req_rm = rm;
    @(negedge g_clk);
    req_valid = 0;
    req_op = 5'($urandom); req_a = $urandom;
    req_b = $urandom; req_c = $urandom;
    req_rm = 3'($urandom);
    chk("unit_a", unit_a, a);
    chk("unit_b", unit_b, beff);
    chk("unit_c", unit_c, c);
    chk("unit_rm", unit_rm, rm);
    if (k == 0) begin
      chk("start", unit_start, 4'b1 << u);
      chk("issue_no_rsp", rsp_valid, 0);
      eres = ures; eerr = 0;
      for (int i = 0; i <= dly; i++) begin
        if (i > 0) begin
          chk("start_off", unit_start, 0);
          chk("wait_no_rsp", rsp_valid, 0);
        end
        unit_done = noise ? (4'($urandom) & ~(4'b1 << u)) : 4'b0;
        unit_res = {$urandom, $urandom, $urandom, $urandom};
        if (i == dly) begin
          unit_done[u] = 1'b1;
          unit_res[u*32 +: 32] = ures;
        end
        @(negedge g_clk);
      end
      unit_done = 0;
    end else begin
      chk("no_start", unit_start, 0);
      if (k == 1) begin
        eres = comb_fix_en ? comb_fix : (a ^ beff);
        eerr = 0;
      end else begin
        eres = QNAN;
        eerr = 1;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_res", rsp_res, eres);
      chk("rsp_err", rsp_err, eerr);
      chk("rsp_stall", stall, 1);
      chk("rsp_not_ready", req_ready, 0);
      if (noise) unit_done = 4'($urandom);
      rsp_ready = (h == hold);
      if (h == hold && bypass) begin
        req_valid = 1; req_op = 5'b00101;
      end
      @(negedge g_clk);
    end
    rsp_ready = 0;
    unit_done = 0;
    req_valid = 0;
    chk("back_idle", rsp_valid, 0);
    chk("back_ready", req_ready, 1);
    chk("back_start", unit_start, 0);
  endtask

  task automatic issue_div();
    @(negedge g_clk);
    req_valid = 1; req_op = 5'b00011;
    req_a = 32'h40800000; req_b = 32'h40000000;
    @(negedge g_clk);
    req_valid = 0;
    chk("div_start", unit_start, 4'b0100);
  endtask

  initial begin
    int n;
    #3;
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_res", rsp_res, 0);
    chk("rst_start", unit_start, 0);
    chk("rst_unit_a", unit_a, 0);
    chk("rst_unit_b", unit_b, 0);
    chk("rst_unit_rm", unit_rm, 0);
    chk("rst_stall", stall, 0);
    @(negedge g_clk);
    g_rst_n = 1;

    run_txn(5'b00000, 32'h3f800000, 32'h40000000, 0, 3'd0,
            3, 0, 0, 32'h40400000, 0);
    run_txn(5'b00001, 32'h3f800000, 32'h40000000, 0, 3'd1,
            1, 1, 0, 32'hbf800000, 0);
    comb_fix_en = 1; comb_fix = 32'hbf800000;
    run_txn(5'b00101, 32'h3f800000, 32'hbf800000, 0, 3'd0,
            0, 0, 0, 0, 1);
    comb_fix_en = 0;
    run_txn(5'b11000, 32'h12345678, 32'h9abcdef0, 0, 3'd2,
            0, 5, 0, 0, 0);
    run_txn(5'b00100, 1, 2, 3, 3'd4, 0, 1, 0, 0, 0);

    for (int t = 0; t < 150; t++) begin
      run_txn(5'($urandom), $urandom, $urandom, $urandom,
              3'($urandom), $urandom_range(0, 6),
              $urandom_range(0, 3), 1'($urandom),
              $urandom, 1'($urandom));
    end

    issue_div();
`ifdef FPU_DISPATCH_TIMEOUT_EN
    n = 1;
    while (!rsp_valid && n < 200) begin
      @(negedge g_clk);
      n++;
    end
    chk("timeout_cycles", n, 66);
    chk("timeout_res", rsp_res, QNAN);
    chk("timeout_err", rsp_err, 1);
    rsp_ready = 1;
    @(negedge g_clk);
    rsp_ready = 0;
    chk("timeout_idle", rsp_valid, 0);
    issue_div();
`else
    n = 0;
    repeat (80) @(negedge g_clk);
    chk("wait_forever", rsp_valid, 0);
    chk("wait_stall", stall, 1);
`endif
    repeat (5) @(negedge g_clk);
    chk("pre_rst_stall", stall, 1);
    #2 g_rst_n = 0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_stall", stall, 0);
    chk("midrst_unit_a", unit_a, 0);
    chk("midrst_start", unit_start, 0);
    @(negedge g_clk);
    g_rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      unit_done = 4'b0100;
      unit_res = {$urandom, $urandom, $urandom, $urandom};
      @(negedge g_clk);
      chk("late_done_valid", rsp_valid, 0);
      chk("late_done_ready", req_ready, 1);
      chk("late_done_start", unit_start, 0);
    end
    unit_done = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_dispatch.md
FPU_DISPATCH -- requirements
Module: fpu_dispatch

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter N_UNITS, default 4, number of multi-cycle execution units served.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64, watchdog limit in cycles.
REQ-004 SHALL have port g_clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port g_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports req_valid input 1, req_ready output 1: request handshake.
REQ-007 SHALL have ports req_op input 5 (fpusel code), req_a/req_b/req_c input XLEN each, req_rm input 3.
REQ-008 SHALL have port unit_start  output  N_UNITS  one-hot start pulse.
REQ-009 SHALL have ports unit_a/unit_b/unit_c output XLEN each, unit_rm output 3: latched operands.
REQ-010 SHALL have ports unit_done input N_UNITS, unit_res input N_UNITS*XLEN (unit i at bits i*XLEN +: XLEN).
REQ-011 SHALL have port comb_res  input  XLEN  result of combinational ops (sign-inject, compare, class, move) on unit_a/unit_b.
REQ-012 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_res output XLEN, rsp_err output 1.
REQ-013 SHALL have port stall  output  1  pipeline hold request.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; stall = (state != IDLE) || (req_valid && !req_ready).
REQ-016 SHALL, on req_valid in IDLE, latch operands; for op 5'b00001 (fsub) unit_b = {~req_b[XLEN-1], req_b[XLEN-2:0]}.
REQ-017 SHALL map op to unit index via package function: add/sub->0, mul->1, div->2, fma 5'b100xx->3, cvt 5'b101xx->(N_UNITS>4 ? 4 : 3).
REQ-018 SHALL, for combinational ops 5'b00101-5'b01111, go IDLE->RESP capturing comb_res one cycle after acceptance (latency 1).
REQ-019 SHALL, for multi-cycle ops, go IDLE->ISSUE->WAIT, asserting unit_start[idx] for exactly the ISSUE cycle.
REQ-020 SHALL accept unit_done[idx] in ISSUE or WAIT, capture unit_res slice idx, and enter RESP next cycle.
REQ-021 SHALL ignore unit_done bits of non-selected units.
REQ-022 SHALL, for unmapped ops (5'b00100, 5'b11xxx) or idx >= N_UNITS, go to RESP with rsp_res=32'h7fc00000, rsp_err=1.
REQ-023 SHALL hold rsp_valid, rsp_res, rsp_err stable in RESP until rsp_ready; on rsp_ready return to IDLE.
REQ-024 SHALL not accept a new request in the cycle rsp_ready completes a response (no back-to-back bypass).

Reset
REQ-025 SHALL, on g_rst_n low, asynchronously enter IDLE with unit_start=0, rsp_valid=0, rsp_err=0, rsp_res=0, unit_a/b/c=0, unit_rm=0, counter=0.
REQ-026 SHALL, on reset mid-operation, abandon the in-flight op; late unit_done after reset is ignored in IDLE.

Configuration
REQ-027 SHALL honour macro FPU_DISPATCH_TIMEOUT_EN: when defined, a counter runs in WAIT; at TIMEOUT_CYC cycles without done go to RESP with rsp_res=32'h7fc00000, rsp_err=1.
REQ-028 SHALL, without FPU_DISPATCH_TIMEOUT_EN, wait in WAIT indefinitely and contain no counter logic.

Structure
REQ-029 SHALL place the fpusel opcode constants, state enum, canonical NaN constant and op-to-unit function in shared package fpu_pkg.
REQ-030 SHALL be a single module with no sub-modules.

Verification
REQ-031 SHALL cover: fadd a=32'h3f800000 b=32'h40000000, unit0 done 3 cycles after start with 32'h40400000 -> start[0] one cycle, rsp_res=32'h40400000, err=0.
REQ-032 SHALL cover: fsub b=32'h40000000 -> unit_b=32'hc0000000 observed at start.
REQ-033 SHALL cover: fsgnj op 5'b00101, comb_res=32'hbf800000 -> rsp_valid next cycle, rsp_res=32'hbf800000, no unit_start.
REQ-034 SHALL cover: op 5'b11000 -> rsp_res=32'h7fc00000, rsp_err=1; rsp_ready held low 5 cycles -> outputs stable, stall=1.
REQ-035 SHALL cover: with FPU_DISPATCH_TIMEOUT_EN, fdiv with no done -> RESP after 64 WAIT cycles, err=1.
REQ-036 SHALL cover: g_rst_n low in WAIT -> IDLE immediately, rsp_valid=0; subsequent unit_done[2] ignored.
